// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every signal between the two memory requesters, the shared memory
// array and mem_port_arbiter.
//
//   slave  : arbiter view (requests and mem_rdata in; grants, responses,
//            lock status and the memory command out)
//   master : environment view (requesters plus memory array)
//
// Signal groups:
//   p0_* / p1_*   request/grant handshake and read response per port
//   p1_lock       port 1 asks for exclusive ownership
//   lock_active   exclusive ownership in effect
//   mem_*         single-port memory command and read data
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) ();

  // Port 0 (CPU side)
  logic                  p0_req;
  logic                  p0_we;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata;

  // Port 1 (JTAG programming controller)
  logic                  p1_req;
  logic                  p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] p1_rdata;

  // Exclusive ownership
  logic                  p1_lock;
  logic                  lock_active;

  // Memory array side
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_lock,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output lock_active,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output p1_lock,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  lock_active,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single read/write port of the instruction/data memory between
// the CPU requester (port 0) and the JTAG programming controller (port 1).
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   mem_port_arbiter_if.slave (handshakes, lock, memory command)
//
// Behaviour summary:
//   - Port 1 has priority on contention; port 0 is forced through after it
//     has waited STARVE_LIMIT consecutive cycles.
//   - p1_lock walks SHARED -> DRAIN -> LOCKED.  Port 0 is blocked from the
//     very cycle p1_lock rises; DRAIN lets an in-flight port 0 read return
//     before lock_active is reported.
//   - Reads return one cycle after the grant, steered to the granting port.
//   - While rst is high every output is held at 0, so stale state is never
//     visible during the reset cycles and a pending response is dropped.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8     // legal range 1..255
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_SHARED = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_q,  wait_d;
  logic              pend0_q, pend1_q;

  logic              p0_eligible;
  logic              starved;
  logic              p0_win;
  logic              p0_gnt, p1_gnt;
  logic              mem_we_mux;
  logic [ADDR_WIDTH-1:0] mem_addr_mux;
  logic [DATA_WIDTH-1:0] mem_wdata_mux;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin : next_state
    // NOTE: every variable in a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_SHARED: if (bus.p1_lock) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.p1_lock)  state_d = ST_SHARED;
        else if (!pend0_q) state_d = ST_LOCKED;
      end
      ST_LOCKED: if (!bus.p1_lock) state_d = ST_SHARED;
      default:   state_d = ST_SHARED;
    endcase
  end

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  // p1_lock is looked at directly in SHARED so port 0 is shut out in the same
  // cycle the lock request appears, not one cycle later.
  assign p0_eligible = (state_q == ST_SHARED) && !bus.p1_lock;
  assign starved     = (wait_q == CNT_MAX);

  // Port 0 wins when eligible and either alone or starved; otherwise any
  // port 1 request wins.  Grants are mutually exclusive by construction.
  assign p0_win = p0_eligible && bus.p0_req && (!bus.p1_req || starved);
  assign p0_gnt = !rst && p0_win;
  assign p1_gnt = !rst && bus.p1_req && !p0_win;

  // Memory command: granted port's fields, all zero when idle.
  always_comb begin : mem_mux
    mem_we_mux    = 1'b0;
    mem_addr_mux  = '0;
    mem_wdata_mux = '0;
    if (p0_gnt) begin
      mem_we_mux    = bus.p0_we;
      mem_addr_mux  = bus.p0_addr;
      mem_wdata_mux = bus.p0_wdata;
    end else if (p1_gnt) begin
      mem_we_mux    = bus.p1_we;
      mem_addr_mux  = bus.p1_addr;
      mem_wdata_mux = bus.p1_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Starvation counter: counts consecutive refused port 0 cycles while the
  // arbiter stays in SHARED; any grant, idle cycle or lock request clears it.
  // -------------------------------------------------------------------------
  always_comb begin : wait_next
    wait_d = '0;
    if (p0_eligible && bus.p0_req && !p0_gnt) begin
      wait_d = starved ? wait_q : wait_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q <= ST_SHARED;
      wait_q  <= '0;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend0_q <= p0_gnt && !bus.p0_we;
      pend1_q <= p1_gnt && !bus.p1_we;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.p0_gnt      = p0_gnt;
  assign bus.p1_gnt      = p1_gnt;
  assign bus.p0_rvalid   = !rst && pend0_q;
  assign bus.p1_rvalid   = !rst && pend1_q;
  assign bus.p0_rdata    = bus.p0_rvalid ? bus.mem_rdata : '0;
  assign bus.p1_rdata    = bus.p1_rvalid ? bus.mem_rdata : '0;
  assign bus.lock_active = !rst && (state_q == ST_LOCKED);

  assign bus.mem_en    = p0_gnt || p1_gnt;
  assign bus.mem_we    = mem_we_mux;
  assign bus.mem_addr  = mem_addr_mux;
  assign bus.mem_wdata = mem_wdata_mux;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter: reset, a table of single-port and
// contention vectors, hand-written lock / release / abort sequences, then
// random traffic compared against a cycle-level behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are compared on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SL = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Memory array: write commits at the edge, read data appears next cycle.
  bit [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, act, exp);
    end
  endtask

  // {gnt0, gnt1, rvalid0, rvalid1, lock_active, mem_en, mem_we, mem_addr,
  //  mem_wdata, rdata0, rdata1}
  function automatic logic [127:0] pack(input logic g0, g1, rv0, rv1, la, en, we,
                                        input logic [AW-1:0] addr,
                                        input logic [DW-1:0] wd, rd0, rd1);
    return {15'b0, g0, g1, rv0, rv1, la, en, we, addr, wd, rd0, rd1};
  endfunction

  function automatic logic [127:0] outs();
    return pack(bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid, bus.lock_active,
                bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                bus.p0_rdata, bus.p1_rdata);
  endfunction

  task automatic drive(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic lk);
    bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
    bus.p1_lock = lk;
  endtask

  // Compare on the falling edge, then move to just after the next rising edge.
  task automatic step_check(input string name, input logic [127:0] exp);
    @(negedge clk);
    check(name, outs(), exp);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic            r0, w0;
    logic [AW-1:0]   a0;
    logic [DW-1:0]   d0;
    logic            r1, w1;
    logic [AW-1:0]   a1;
    logic [DW-1:0]   d1;
    logic [127:0]    exp;
  } vec_t;

  vec_t vecs [22];

  // Random-phase model state
  logic            r0, w0, r1, w1, lk, rr;
  logic [AW-1:0]   a0, a1;
  logic [DW-1:0]   d0, d1;
  logic            hold0, hold1;
  logic            lock_prev;
  int              lock_run;
  int              wait_m;
  logic            pv0, pv1;
  logic [DW-1:0]   pd0, pd1;
  bit   [DW-1:0]   ref_mem [0:(1<<AW)-1];

  initial begin
    // ---------------- vector table ----------------
    vecs[0] = '{1, 1, 10'h005, 32'hDEADBEEF, 0, 0, 0, 0,
                pack(1, 0, 0, 0, 0, 1, 1, 10'h005, 32'hDEADBEEF, 0, 0)};
    vecs[1] = '{1, 0, 10'h005, 0, 0, 0, 0, 0,
                pack(1, 0, 0, 0, 0, 1, 0, 10'h005, 0, 0, 0)};
    vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 0,
                pack(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0)};
    // Continuous contention: p1 wins 8 cycles, p0 the 9th, repeating.
    // p1 fields advance only after p1 has been granted (held while waiting).
    for (int k = 0; k < 18; k++) begin
      logic            win0, prev0;
      logic [AW-1:0]   pa;
      logic [DW-1:0]   pd;
      int              j;
      win0  = (k % 9) == 8;
      prev0 = (k > 0) && (((k - 1) % 9) == 8);
      j     = k - k / 9;
      pa    = AW'(10'h040 + j);
      pd    = DW'(32'h100 + j);
      vecs[3+k].r0 = 1; vecs[3+k].w0 = 0; vecs[3+k].a0 = 10'h005; vecs[3+k].d0 = 0;
      vecs[3+k].r1 = 1; vecs[3+k].w1 = 1; vecs[3+k].a1 = pa;      vecs[3+k].d1 = pd;
      vecs[3+k].exp = win0
        ? pack(1, 0, prev0, 0, 0, 1, 0, 10'h005, 0, prev0 ? 32'hDEADBEEF : 32'h0, 0)
        : pack(0, 1, prev0, 0, 0, 1, 1, pa, pd, prev0 ? 32'hDEADBEEF : 32'h0, 0);
    end
    vecs[21] = '{0, 0, 0, 0, 0, 0, 0, 0,
                 pack(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0)};

    // ---------------- reset with both ports requesting ----------------
    rst = 1'b1;
    drive(1, 0, 10'h001, 0, 1, 0, 10'h002, 0, 0);
    @(posedge clk); #1;
    step_check("reset_c1", '0);
    step_check("reset_c2", '0);
    rst = 1'b0;
    step_check("reset_release", pack(0, 1, 0, 0, 0, 1, 0, 10'h002, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step_check("first_p1_resp", pack(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
            vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1, 0);
      step_check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ---------------- lock entry with an in-flight port 0 read ----------------
    drive(1, 1, 10'h010, 32'h12345678, 0, 0, 0, 0, 0);
    step_check("lock_pre_wr", pack(1, 0, 0, 0, 0, 1, 1, 10'h010, 32'h12345678, 0, 0));
    drive(1, 0, 10'h010, 0, 0, 0, 0, 0, 0);
    step_check("lock_p0_rd", pack(1, 0, 0, 0, 0, 1, 0, 10'h010, 0, 0, 0));
    drive(1, 0, 10'h010, 0, 1, 1, 10'h030, 32'h55AA, 1);
    step_check("lock_rise", pack(0, 1, 1, 0, 0, 1, 1, 10'h030, 32'h55AA, 32'h12345678, 0));
    drive(1, 0, 10'h010, 0, 1, 0, 10'h030, 0, 1);
    step_check("lock_drain", pack(0, 1, 0, 0, 0, 1, 0, 10'h030, 0, 0, 0));
    drive(1, 0, 10'h010, 0, 1, 1, 10'h031, 32'hA5, 1);
    step_check("lock_active", pack(0, 1, 0, 1, 1, 1, 1, 10'h031, 32'hA5, 0, 32'h55AA));
    drive(1, 0, 10'h010, 0, 1, 0, 10'h031, 0, 1);
    step_check("lock_hold", pack(0, 1, 0, 0, 1, 1, 0, 10'h031, 0, 0, 0));
    // ---------------- release ----------------
    drive(1, 0, 10'h010, 0, 0, 0, 0, 0, 0);
    step_check("release_edge", pack(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'hA5));
    step_check("release_p0", pack(1, 0, 0, 0, 0, 1, 0, 10'h010, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step_check("release_resp", pack(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h12345678, 0));

    // ---------------- abort: reset right after a p1 read grant in LOCKED ----------------
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step_check("abort_lock1", '0);
    step_check("abort_lock2", '0);
    drive(0, 0, 0, 0, 1, 0, 10'h031, 0, 1);
    step_check("abort_p1_rd", pack(0, 1, 0, 0, 1, 1, 0, 10'h031, 0, 0, 0));
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step_check("abort_rst", '0);
    rst = 1'b0;
    drive(1, 0, 10'h010, 0, 0, 0, 0, 0, 0);
    step_check("abort_after", pack(1, 0, 0, 0, 0, 1, 0, 10'h010, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step_check("abort_p0_resp", pack(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h12345678, 0));

    // ---------------- random traffic vs behavioural model ----------------
    hold0 = 0; hold1 = 0; lock_prev = 0; lock_run = 0; wait_m = 0;
    pv0 = 0; pv1 = 0; pd0 = 0; pd1 = 0; lk = 0;
    r0 = 0; r1 = 0; w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    for (int c = 0; c < 3000; c++) begin
      logic            elig0, eg0, eg1, en, we, la;
      logic [AW-1:0]   ad;
      logic [DW-1:0]   wd;
      logic [127:0]    exp;
      if (!hold0) begin
        r0 = ($urandom_range(0, 3) != 0);
        w0 = $urandom_range(0, 1) == 1;
        a0 = AW'(10'h100 + $urandom_range(0, 15));
        d0 = $urandom;
      end
      if (!hold1) begin
        r1 = ($urandom_range(0, 9) != 0);
        w1 = $urandom_range(0, 1) == 1;
        a1 = AW'(10'h100 + $urandom_range(0, 15));
        d1 = $urandom;
      end
      if ($urandom_range(0, 24) == 0) lk = ~lk;
      rr = ($urandom_range(0, 99) == 0);
      rst = rr;
      drive(r0, w0, a0, d0, r1, w1, a1, d1, lk);

      // Port 0 may only win if lock is low now and was low last cycle
      // (a lock seen last cycle means the arbiter is draining or locked).
      elig0 = !lk && !lock_prev;
      eg0   = !rr && elig0 && r0 && (!r1 || wait_m == SL);
      eg1   = !rr && r1 && !eg0;
      en    = eg0 || eg1;
      we    = eg0 ? w0 : (eg1 ? w1 : 1'b0);
      ad    = eg0 ? a0 : (eg1 ? a1 : '0);
      wd    = eg0 ? d0 : (eg1 ? d1 : '0);
      la    = !rr && (lock_run >= 2);
      exp   = rr ? '0 : pack(eg0, eg1, pv0, pv1, la, en, we, ad, wd,
                             pv0 ? pd0 : '0, pv1 ? pd1 : '0);
      @(negedge clk);
      check("rand", outs(), exp);

      if (rr) begin
        wait_m = 0; pv0 = 0; pv1 = 0; lock_run = 0; lock_prev = 0;
      end else begin
        pv0 = eg0 && !w0; pd0 = ref_mem[a0];
        pv1 = eg1 && !w1; pd1 = ref_mem[a1];
        if (eg0 && w0) ref_mem[a0] = d0;
        if (eg1 && w1) ref_mem[a1] = d1;
        if (elig0 && r0 && !eg0) wait_m = (wait_m < SL) ? wait_m + 1 : wait_m;
        else                     wait_m = 0;
        lock_run  = lk ? ((lock_run < 2) ? lock_run + 1 : 2) : 0;
        lock_prev = lk;
      end
      hold0 = r0 && !eg0;
      hold1 = r1 && !eg1;
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter
